seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that adds two WIDTH-bit operands CHUNK bits per clock. A registered carry chains the chunks, so hardware cost scales with CHUNK rather than WIDTH. It is the configurable successor to the fixed 16-bit combinational ripple adder, and adds a start/done handshake, a subtract mode and a signed-overflow flag. It is intended for datapaths where area matters more than single-cycle latency.

---
 rtl/seq_adder_pkg.sv | 10 +
 rtl/ripple_n.sv | 19 +
 rtl/seq_chunk_adder.sv | 133 +++++++++++++
 tb/tb_seq_chunk_adder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_adder_pkg.sv
// Shared types for the chunked sequential adder.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ripple_n.sv
// Combinational N-bit ripple-carry adder; also reports the carry into its top bit.
module ripple_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c_in,
  output logic [N-1:0] o_s,
  output logic         o_c_out,
  output logic         o_c_msb
);

  always_comb begin
    {o_c_out, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c_in};
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    o_c_msb = o_s[N-1] ^ i_a[N-1] ^ i_b[N-1];
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered carry.
//
//   state | meaning
//   IDLE  | waiting for start; last result held on outputs
//   RUN   | one chunk added per edge, idx selects the chunk
//   DONE  | one-cycle done pulse; start here chains the next op
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum;
  logic             w_c_out;
  logic             w_c_msb;

  always_comb begin
    w_a_chunk = '0;
    w_b_chunk = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_a_chunk = r_a[k*CHUNK +: CHUNK];
        w_b_chunk = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  ripple_n #(
    .N (CHUNK)
  ) u_ripple (
    .i_a     (w_a_chunk),
    .i_b     (w_b_chunk),
    .i_c_in  (r_c),
    .o_s     (w_sum),
    .o_c_out (w_c_out),
    .o_c_msb (w_c_msb)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            // Subtract is A + ~B + 1; the +1 rides in on the initial carry.
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_c     <= i_sub ? 1'b1 : i_cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          for (int k = 0; k < NCH; k++) begin
            if (r_idx == IDXW'(k)) r_s[k*CHUNK +: CHUNK] <= w_sum;
          end
          r_c <= w_c_out;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_c_out;
            r_ovf   <= w_c_out ^ w_c_msb;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder across five WIDTH/CHUNK configurations.
module tb_seq_chunk_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  // cfg: 0=(16,4) 1=(16,1) 2=(16,8) 3=(16,16) 4=(32,8)
  int cfg_w   [5] = '{16, 16, 16, 16, 32};
  int cfg_nch [5] = '{4, 16, 2, 1, 4};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  start_v = '0;
  logic [4:0]  sub_v   = '0;
  logic [4:0]  cin_v   = '0;
  logic [15:0] a16 [4];
  logic [15:0] b16 [4];
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;

  wire  [4:0]  busy_v;
  wire  [4:0]  done_v;
  wire  [4:0]  cout_v;
  wire  [4:0]  ovf_v;
  wire  [15:0] s16 [4];
  wire  [31:0] s32;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  time  last_done_t = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c0 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_sub(sub_v[0]), .i_a(a16[0]), .i_b(b16[0]),
    .i_cin(cin_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0]), .o_s(s16[0]), .o_cout(cout_v[0]), .o_ovf(ovf_v[0]));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_sub(sub_v[1]), .i_a(a16[1]), .i_b(b16[1]),
    .i_cin(cin_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1]), .o_s(s16[1]), .o_cout(cout_v[1]), .o_ovf(ovf_v[1]));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(8)) u_c2 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_sub(sub_v[2]), .i_a(a16[2]), .i_b(b16[2]),
    .i_cin(cin_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2]), .o_s(s16[2]), .o_cout(cout_v[2]), .o_ovf(ovf_v[2]));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c3 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[3]), .i_sub(sub_v[3]), .i_a(a16[3]), .i_b(b16[3]),
    .i_cin(cin_v[3]), .o_busy(busy_v[3]), .o_done(done_v[3]), .o_s(s16[3]), .o_cout(cout_v[3]), .o_ovf(ovf_v[3]));
  seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_c4 (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[4]), .i_sub(sub_v[4]), .i_a(a32), .i_b(b32),
    .i_cin(cin_v[4]), .o_busy(busy_v[4]), .o_done(done_v[4]), .o_s(s32), .o_cout(cout_v[4]), .o_ovf(ovf_v[4]));

  function automatic logic [31:0] get_s(input int c);
    logic [31:0] v;
    case (c)
      0: v = {16'h0, s16[0]};
      1: v = {16'h0, s16[1]};
      2: v = {16'h0, s16[2]};
      3: v = {16'h0, s16[3]};
      default: v = s32;
    endcase
    return v;
  endfunction

  // Reference: modular add of A and (possibly inverted) B; overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] aa;
    logic [31:0] bb;
    logic [32:0] full;
    mask   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    aa     = a & mask;
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {32'h0, (sub ? 1'b1 : cin)};
    e.s    = full[31:0] & mask;
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (e.s[w-1] != aa[w-1]);
    return e;
  endfunction

  task automatic drive_ops(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub);
    if (c == 4) begin
      a32 = a;
      b32 = b;
    end else begin
      a16[c] = a[15:0];
      b16[c] = b[15:0];
    end
    cin_v[c] = cin;
    sub_v[c] = sub;
  endtask

  // Launch one operation, push its expectation, wait for done and score it.
  // disturb > 0 re-pulses start with other operands that many cycles into RUN.
  task automatic run_op(input int c, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input exp_t e,
                        input int disturb, input string name);
    exp_t        got_e;
    int          cyc;
    int          nb;
    logic        seen;
    logic [31:0] got_s;
    sb_q.push_back(e);
    @(negedge clk);
    drive_ops(c, a, b, cin, sub);
    start_v[c] = 1'b1;
    @(posedge clk);
    #1;
    start_v[c] = 1'b0;
    n_checks++;
    if (busy_v[c] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_accept cfg%0d: got %b want 1", name, c, busy_v[c]);
    end
    nb   = busy_v[c] ? 1 : 0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (disturb > 0 && cyc == disturb) begin
        drive_ops(c, ~a, a ^ b, ~cin, ~sub);
        start_v[c] = 1'b1;
      end
      if (disturb > 0 && cyc == disturb + 1) start_v[c] = 1'b0;
      if (busy_v[c] && done_v[c]) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s busy_and_done cfg%0d at cycle %0d", name, c, cyc);
      end
      if (done_v[c]) begin
        seen = 1'b1;
        last_done_t = $time;
      end else if (busy_v[c]) begin
        nb++;
      end
    end
    got_e = sb_q.pop_front();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s done_timeout cfg%0d: no done within %0d cycles", name, c, cyc);
    end else begin
      got_s = get_s(c);
      if (got_s !== got_e.s) begin
        n_fail++;
        $display("FAIL %s sum cfg%0d a=%h b=%h cin=%b sub=%b: got %h want %h", name, c, a, b, cin, sub, got_s, got_e.s);
      end
      n_checks++;
      if (cout_v[c] !== got_e.cout) begin
        n_fail++;
        $display("FAIL %s cout cfg%0d a=%h b=%h sub=%b: got %b want %b", name, c, a, b, sub, cout_v[c], got_e.cout);
      end
      n_checks++;
      if (ovf_v[c] !== got_e.ovf) begin
        n_fail++;
        $display("FAIL %s ovf cfg%0d a=%h b=%h sub=%b: got %b want %b", name, c, a, b, sub, ovf_v[c], got_e.ovf);
      end
      n_checks++;
      if (cyc != cfg_nch[c]) begin
        n_fail++;
        $display("FAIL %s latency cfg%0d: got %0d want %0d", name, c, cyc, cfg_nch[c]);
      end
      n_checks++;
      if (nb != cfg_nch[c]) begin
        n_fail++;
        $display("FAIL %s busy_cycles cfg%0d: got %0d want %0d", name, c, nb, cfg_nch[c]);
      end
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic co, input logic ov);
    exp_t e;
    e.s = s; e.cout = co; e.ovf = ov;
    return e;
  endfunction

  task automatic check_zero(input int c, input string name);
    n_checks++;
    if (busy_v[c] !== 1'b0 || done_v[c] !== 1'b0 || get_s(c) !== 32'h0 ||
        cout_v[c] !== 1'b0 || ovf_v[c] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s cfg%0d: busy=%b done=%b s=%h cout=%b ovf=%b want all 0",
               name, c, busy_v[c], done_v[c], get_s(c), cout_v[c], ovf_v[c]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      a16[i] = '0;
      b16[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) check_zero(c, "reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] held;
    run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b0, mk(32'h0000, 1'b1, 1'b0), 0, "add_wrap");
    @(negedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (done_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: got %b want 0", done_v[0]);
    end
    run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, mk(32'h8000, 1'b0, 1'b1), 0, "add_ovf");
    run_op(0, 32'h1234, 32'h4321, 1'b1, 1'b0, mk(32'h5556, 1'b0, 1'b0), 0, "add_cin");
    repeat (3) @(posedge clk);
    #1;
    held = get_s(0);
    n_checks++;
    if (held !== 32'h5556 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: s=%h busy=%b want 5556 busy 0", held, busy_v[0]);
    end
  endtask

  task automatic test_sub();
    run_op(0, 32'h0005, 32'h0007, 1'b0, 1'b1, mk(32'hFFFE, 1'b0, 1'b0), 0, "sub_borrow");
    run_op(0, 32'h8000, 32'h0001, 1'b1, 1'b1, mk(32'h7FFF, 1'b1, 1'b1), 0, "sub_ovf");
  endtask

  task automatic test_midrun_ignore();
    run_op(0, 32'h1111, 32'h2222, 1'b0, 1'b0, mk(32'h3333, 1'b0, 1'b0), 2, "midrun_ignore");
  endtask

  task automatic test_back_to_back();
    time t1;
    run_op(0, 32'h00F0, 32'h0F10, 1'b0, 1'b0, mk(32'h1000, 1'b0, 1'b0), 0, "b2b_first");
    t1 = last_done_t;
    run_op(0, 32'h0001, 32'h0002, 1'b0, 1'b1, mk(32'hFFFF, 1'b0, 1'b0), 0, "b2b_second");
    n_checks++;
    if (last_done_t - t1 != time'((cfg_nch[0] + 1) * 10)) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0t want %0d", last_done_t - t1, (cfg_nch[0] + 1) * 10);
    end
  endtask

  task automatic test_reset_midrun();
    int dn;
    @(negedge clk);
    drive_ops(0, 32'h00FF, 32'h0F0F, 1'b0, 1'b0);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_zero(0, "reset_midrun");
    dn = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dn++;
    end
    n_checks++;
    if (dn != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done cycles want 0", dn);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 32'h00FF, 32'h0F0F, 1'b0, 1'b0, mk(32'h100E, 1'b0, 1'b0), 0, "after_reset");
  endtask

  task automatic test_sweep(input int c, input int n);
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    for (int i = 0; i < n; i++) begin
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      if (cfg_w[c] == 16) begin
        a[31:16] = '0;
        b[31:16] = '0;
      end
      run_op(c, a, b, cin, sub, model(cfg_w[c], a, b, cin, sub), 0, "sweep");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_midrun_ignore();
    test_back_to_back();
    test_reset_midrun();
    test_sweep(0, 200);
    test_sweep(1, 1000);
    test_sweep(2, 1000);
    test_sweep(3, 1000);
    test_sweep(4, 1000);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
